// File: rtl/link_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : link_rx_ctrl
// Brief    : Fiber link receive controller. It hunts for frame alignment,
//            qualifies lock over several frames, and deserializes 8-bit
//            payloads. Defining the macro LINKRX_ERRCNT_EN adds the o_ErrCnt
//            error counter.
// Revision : 1.0 - initial release
// ============================================================================
module link_rx_ctrl #(
    parameter logic [3:0] SYNC_PAT     = 4'hB,
    parameter int         LOCK_FRAMES  = 4,
    parameter int         LOSS_FRAMES  = 3,
    parameter int         TIMEOUT_CLKS = 64
) (
    input  logic        i_clk,
    input  logic        i_res_n,
    input  logic        i_RecoveryData,
    input  logic        i_DataEn,
    output logic [7:0]  o_Payload,
    output logic        o_PayloadEn,
    output logic        o_LinkUp,
    output logic [1:0]  o_State
`ifdef LINKRX_ERRCNT_EN
    ,
    output logic [15:0] o_ErrCnt
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]  c_LOCK_LAST = 4'(LOCK_FRAMES - 1);
    localparam logic [3:0]  c_LOSS_LAST = 4'(LOSS_FRAMES - 1);
    localparam logic [15:0] c_TMO_LAST  = 16'(TIMEOUT_CLKS - 1);
    localparam logic [15:0] c_TMO_SAT   = 16'(TIMEOUT_CLKS);
    localparam logic [4:0]  c_WIN_BITS  = 5'd16;

    state_t      r_state;
    state_t      w_state_nxt;

    // The oldest window bit is never read again, so only 15 bits are kept.
    logic [14:0] r_shift;
    logic [4:0]  r_bitcnt;
    logic [3:0]  r_frmcnt;
    logic [3:0]  r_good;
    logic [3:0]  r_bad;
    logic [15:0] r_timer;
    logic [7:0]  r_payload;
    logic        r_payload_en;
    logic        r_linkup;

    logic [15:0] w_win;
    logic [3:0]  w_chk;
    logic        w_good;
    logic        w_hunt_full;
    logic        w_boundary;
    logic        w_expire;

    logic        w_hunt_hit;
    logic        w_good_inc;
    logic        w_bad_inc;
    logic        w_bad_clr;
    logic        w_emit;

    assign w_win       = {r_shift, i_RecoveryData};
    assign w_chk       = w_win[11:8] ^ w_win[7:4] ^ 4'h5;
    assign w_good      = (w_win[15:12] == SYNC_PAT) && (w_win[3:0] == w_chk);
    // The incoming bit completes a window of 16 bits received since HUNT entry.
    assign w_hunt_full = (r_bitcnt >= 5'd15);
    assign w_boundary  = i_DataEn && (r_frmcnt == 4'd15);
    assign w_expire    = !i_DataEn && (r_timer == c_TMO_LAST);

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hunt_hit  = 1'b0;
        w_good_inc  = 1'b0;
        w_bad_inc   = 1'b0;
        w_bad_clr   = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (i_DataEn && w_hunt_full && w_good) begin
                    w_hunt_hit  = 1'b1;
                    w_state_nxt = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (w_expire) begin
                    w_state_nxt = ST_HUNT;
                end else if (w_boundary) begin
                    if (!w_good) begin
                        w_state_nxt = ST_HUNT;
                    end else if (r_good == c_LOCK_LAST) begin
                        w_state_nxt = ST_LOCKED;
                        w_bad_clr   = 1'b1;
                    end else begin
                        w_good_inc  = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_expire) begin
                    w_state_nxt = ST_HUNT;
                end else if (w_boundary) begin
                    if (w_good) begin
                        w_emit    = 1'b1;
                        w_bad_clr = 1'b1;
                    end else if (r_bad == c_LOSS_LAST) begin
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_bad_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_frmcnt     <= '0;
            r_good       <= '0;
            r_bad        <= '0;
            r_timer      <= '0;
            r_payload    <= '0;
            r_payload_en <= 1'b0;
            r_linkup     <= 1'b0;
        end else begin
            if (i_DataEn) begin
                r_shift <= w_win[14:0];
            end

            if (i_DataEn) begin
                r_timer <= '0;
            end else if (r_timer != c_TMO_SAT) begin
                r_timer <= r_timer + 16'd1;
            end

            // Held at zero outside HUNT, so every HUNT entry starts a fresh window.
            if ((r_state != ST_HUNT) || w_expire) begin
                r_bitcnt <= '0;
            end else if (i_DataEn && (r_bitcnt != c_WIN_BITS)) begin
                r_bitcnt <= r_bitcnt + 5'd1;
            end

            if (w_hunt_hit) begin
                r_frmcnt <= '0;
            end else if (i_DataEn && (r_state != ST_HUNT)) begin
                r_frmcnt <= r_frmcnt + 4'd1;
            end

            if (w_hunt_hit) begin
                r_good <= 4'd1;
            end else if (w_good_inc) begin
                r_good <= r_good + 4'd1;
            end

            if (w_hunt_hit || w_bad_clr) begin
                r_bad <= '0;
            end else if (w_bad_inc) begin
                r_bad <= r_bad + 4'd1;
            end

            if (w_emit) begin
                r_payload <= w_win[11:4];
            end
            r_payload_en <= w_emit;
            r_linkup     <= (w_state_nxt == ST_LOCKED);
        end
    end

`ifdef LINKRX_ERRCNT_EN
    logic [15:0] r_errcnt;
    logic        w_err;

    // Bad frames and timeouts only count while synchronised (VERIFY or LOCKED).
    assign w_err = (r_state != ST_HUNT) && (w_expire || (w_boundary && !w_good));

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_errcnt <= '0;
        end else if (w_err && (r_errcnt != 16'hFFFF)) begin
            r_errcnt <= r_errcnt + 16'd1;
        end
    end

    assign o_ErrCnt = r_errcnt;
`endif

    assign o_Payload   = r_payload;
    assign o_PayloadEn = r_payload_en;
    assign o_LinkUp    = r_linkup;
    assign o_State     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_link_rx_ctrl.sv
`default_nettype none
// Testbench for link_rx_ctrl: table-driven frame vectors plus hand-written
// timeout and VERIFY-reject sequences; payload strobes checked via a scoreboard.
module tb_link_rx_ctrl;

    logic        i_clk = 1'b0;
    logic        i_res_n = 1'b0;
    logic        i_RecoveryData = 1'b0;
    logic        i_DataEn = 1'b0;
    logic [7:0]  o_Payload;
    logic        o_PayloadEn;
    logic        o_LinkUp;
    logic [1:0]  o_State;
`ifdef LINKRX_ERRCNT_EN
    logic [15:0] o_ErrCnt;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  sb_q[$];
    logic [7:0]  mon_exp;

    typedef struct {
        logic [15:0] frame;
        logic [1:0]  st;
        logic        up;
        logic        push;
        logic [7:0]  pay;
        logic [15:0] err;
    } vec_t;

    vec_t tbl[10];

    always #5 i_clk = ~i_clk;

    link_rx_ctrl dut (
        .i_clk          (i_clk),
        .i_res_n        (i_res_n),
        .i_RecoveryData (i_RecoveryData),
        .i_DataEn       (i_DataEn),
        .o_Payload      (o_Payload),
        .o_PayloadEn    (o_PayloadEn),
        .o_LinkUp       (o_LinkUp),
        .o_State        (o_State)
`ifdef LINKRX_ERRCNT_EN
        ,
        .o_ErrCnt       (o_ErrCnt)
`endif
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        i_RecoveryData = b;
        i_DataEn       = 1'b1;
        tick(1);
        i_DataEn       = 1'b0;
        tick(3);
    endtask

    // Returns one clock after the edge that consumed the last bit, DataEn low.
    task automatic send_frame(input logic [15:0] f, input logic push, input logic [7:0] pay);
        for (int i = 15; i >= 1; i--) begin
            send_bit(f[i]);
        end
        if (push) begin
            sb_q.push_back(pay);
        end
        i_RecoveryData = f[0];
        i_DataEn       = 1'b1;
        tick(1);
        i_DataEn       = 1'b0;
    endtask

    task automatic acquire(input string tag);
        for (int k = 0; k < 4; k++) begin
            send_frame(16'hB3CA, 1'b0, 8'h00);
            check({tag, "_state"}, 16'(o_State), (k == 3) ? 16'd2 : 16'd1);
            check({tag, "_linkup"}, 16'(o_LinkUp), (k == 3) ? 16'd1 : 16'd0);
            if (k < 3) begin
                tick(3);
            end
        end
    endtask

    always @(negedge i_clk) begin
        if (o_PayloadEn === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: strobe with payload %02h, none expected", o_Payload);
            end else begin
                mon_exp = sb_q.pop_front();
                if (o_Payload !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_payload: got %02h, want %02h", o_Payload, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{16'hB3CA, 2'd1, 1'b0, 1'b0, 8'h00, 16'd0};
        tbl[1] = '{16'hB3CA, 2'd1, 1'b0, 1'b0, 8'h00, 16'd0};
        tbl[2] = '{16'hB3CA, 2'd1, 1'b0, 1'b0, 8'h00, 16'd0};
        tbl[3] = '{16'hB3CA, 2'd2, 1'b1, 1'b0, 8'h00, 16'd0};
        tbl[4] = '{16'hB3CA, 2'd2, 1'b1, 1'b1, 8'h3C, 16'd0};
        tbl[5] = '{16'hB3CB, 2'd2, 1'b1, 1'b0, 8'h00, 16'd1};
        tbl[6] = '{16'hB005, 2'd2, 1'b1, 1'b1, 8'h00, 16'd1};
        tbl[7] = '{16'hB3CB, 2'd2, 1'b1, 1'b0, 8'h00, 16'd2};
        tbl[8] = '{16'hB3CB, 2'd2, 1'b1, 1'b0, 8'h00, 16'd3};
        tbl[9] = '{16'hB3CB, 2'd0, 1'b0, 1'b0, 8'h00, 16'd4};

        // Reset with random activity on the inputs.
        i_res_n = 1'b0;
        repeat (8) begin
            i_DataEn       = 1'($urandom_range(0, 1));
            i_RecoveryData = 1'($urandom_range(0, 1));
            tick(1);
        end
        check("rst_state", 16'(o_State), 16'd0);
        check("rst_linkup", 16'(o_LinkUp), 16'd0);
        check("rst_payload_en", 16'(o_PayloadEn), 16'd0);
        check("rst_payload", 16'(o_Payload), 16'h00);
`ifdef LINKRX_ERRCNT_EN
        check("rst_errcnt", o_ErrCnt, 16'd0);
`endif
        i_DataEn       = 1'b0;
        i_RecoveryData = 1'b0;
        i_res_n        = 1'b1;
        tick(2);

        // Garbage bits ahead of the first frame.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);

        // Acquire, single error, then loss of lock.
        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].frame, tbl[i].push, tbl[i].pay);
            check($sformatf("vec%0d_state", i), 16'(o_State), 16'(tbl[i].st));
            check($sformatf("vec%0d_linkup", i), 16'(o_LinkUp), 16'(tbl[i].up));
`ifdef LINKRX_ERRCNT_EN
            check($sformatf("vec%0d_errcnt", i), o_ErrCnt, tbl[i].err);
`endif
            tick(3);
            check($sformatf("vec%0d_sb_pending", i), 16'(sb_q.size()), 16'd0);
        end
        check("loss_payload_hold", 16'(o_Payload), 16'h00);

        // Timeout: exactly 64 idle clocks in LOCKED forces HUNT.
        acquire("relock1");
        tick(63);
        check("tmo63_state", 16'(o_State), 16'd2);
        tick(1);
        check("tmo64_state", 16'(o_State), 16'd0);
        check("tmo64_linkup", 16'(o_LinkUp), 16'd0);
`ifdef LINKRX_ERRCNT_EN
        check("tmo64_errcnt", o_ErrCnt, 16'd5);
`endif

        // A bit on idle clock 64 wins over expiry and restarts the timer.
        acquire("relock2");
        tick(63);
        i_RecoveryData = 1'b0;
        i_DataEn       = 1'b1;
        tick(1);
        i_DataEn       = 1'b0;
        check("tmo_rescue_state", 16'(o_State), 16'd2);
        check("tmo_rescue_linkup", 16'(o_LinkUp), 16'd1);
        tick(63);
        check("tmo_restart63_state", 16'(o_State), 16'd2);
        tick(1);
        check("tmo_restart64_state", 16'(o_State), 16'd0);
`ifdef LINKRX_ERRCNT_EN
        check("tmo_restart_errcnt", o_ErrCnt, 16'd6);
`endif

        // VERIFY reject, then four good frames to relock.
        send_frame(16'hB3CA, 1'b0, 8'h00);
        check("rej_hit_state", 16'(o_State), 16'd1);
        tick(3);
        send_frame(16'hA3CA, 1'b0, 8'h00);
        check("rej_state", 16'(o_State), 16'd0);
        check("rej_linkup", 16'(o_LinkUp), 16'd0);
`ifdef LINKRX_ERRCNT_EN
        check("rej_errcnt", o_ErrCnt, 16'd7);
`endif
        tick(3);
        acquire("relock3");
        tick(3);
        send_frame(16'hB3CA, 1'b1, 8'h3C);
        check("relock3_emit_state", 16'(o_State), 16'd2);
        tick(3);

        check("sb_drain", 16'(sb_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
